// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter for a bank of parallel-load registers.
// One write is issued per two cycles: IDLE samples requests, LOAD presents pen/pin for one edge.
module reg_bank_write_arbiter #(
  parameter int SIZE = 10,
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*SIZE-1:0] wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREG-1:0]      reg_pen,
  output logic [SIZE-1:0]      reg_pin,
  output logic                 busy,
  output logic                 err
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREG-1:0]     pen_q, pen_d;
  logic [SIZE-1:0]     pin_q, pin_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [2*NREQ-1:0]   req_dbl;
  logic [NREQ-1:0]     req_rot;
  logic [PW-1:0]       rot_ofs;
  logic [PW:0]         win_sum;
  logic [PW-1:0]       win_idx;
  logic [NREQ-1:0]     win_oh;
  logic                any_req;
  logic [PW-1:0]       nxt_ptr;
  logic [AW-1:0]       sel_addr;
  logic [SIZE-1:0]     sel_data;
  logic [NREG-1:0]     addr_oh;

  // Rotate requests so the pointer position becomes bit 0; the lowest set
  // bit of the rotated vector is the winner's distance from the pointer.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NREQ'(req_dbl >> ptr_q);
    any_req = |req;
    rot_ofs = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) rot_ofs = PW'(k);
    end
    win_sum = {1'b0, ptr_q} + {1'b0, rot_ofs};
    if (win_sum >= (PW+1)'(NREQ)) win_sum = win_sum - (PW+1)'(NREQ);
    win_idx = win_sum[PW-1:0];
    nxt_ptr = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
  end

  always_comb begin
    win_oh   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_oh[i] = any_req;
        sel_addr  = addr[i*AW +: AW];
        sel_data  = wdata[i*SIZE +: SIZE];
      end
    end
  end

  // An address outside the bank decodes to an all-zero enable, which flags err.
  always_comb begin
    addr_oh = '0;
    for (int k = 0; k < NREG; k++) begin
      addr_oh[k] = (sel_addr == AW'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    pen_d   = '0;
    pin_d   = pin_q;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = LOAD;
          ptr_d   = nxt_ptr;
          gnt_d   = win_oh;
          pen_d   = addr_oh;
          pin_d   = sel_data;
          busy_d  = 1'b1;
          err_d   = ~|addr_oh;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      pen_q   <= '0;
      pin_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      pen_q   <= pen_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign gnt     = gnt_q;
  assign reg_pen = pen_q;
  assign reg_pin = pin_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a queue-free behavioural arbiter/register-bank model.
module tb_reg_bank_write_arbiter;
  localparam int SIZE = 10;
  localparam int NREQ = 4;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [7:0]  addr;
  logic [39:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  reg_pen;
  logic [9:0]  reg_pin;
  logic        busy, err;

  logic [3:0]  req3;
  logic [7:0]  addr3;
  logic [39:0] wdata3;
  logic [3:0]  gnt3;
  logic [2:0]  pen3;
  logic [9:0]  pin3;
  logic        busy3, err3;

  reg_bank_write_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
    .gnt(gnt), .reg_pen(reg_pen), .reg_pin(reg_pin), .busy(busy), .err(err)
  );

  reg_bank_write_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .NREG(3), .AW(AW)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .addr(addr3), .wdata(wdata3),
    .gnt(gnt3), .reg_pen(pen3), .reg_pin(pin3), .busy(busy3), .err(err3)
  );

  // Stand-ins for the n_bit_reg instances: load pin when pen is high at the edge.
  logic [9:0] bank  [4] = '{default: '0};
  logic [9:0] bank3 [3] = '{default: '0};
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) if (reg_pen[k]) bank[k] <= reg_pin;
    for (int k = 0; k < 3; k++) if (pen3[k]) bank3[k] <= pin3;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {44'b0, gnt, reg_pen, reg_pin, busy, err};
  endfunction

  function automatic logic [63:0] pk(input logic [3:0] g, input logic [3:0] p,
                                     input logic [9:0] d, input logic b, input logic e);
    return {44'b0, g, p, d, b, e};
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [39:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  pen;
    logic [9:0]  pin;
    logic        busy;
    logic        err;
  } vec_t;

  localparam logic [39:0] RRD = {10'h0A3, 10'h0A2, 10'h0A1, 10'h0A0};
  vec_t vecs [12];

  // Behavioural model: pointer as an integer, winner by modular scan.
  bit         m_load;
  int         m_ptr;
  logic [3:0] e_gnt, e_pen;
  logic [9:0] e_pin;
  logic       e_busy, e_err;
  logic [9:0] e_bank [4];
  bit         e_valid [4];

  task automatic model_step(input logic [3:0] r, input logic [7:0] a, input logic [39:0] d);
    int w;
    int c;
    int ta;
    for (int k = 0; k < 4; k++) begin
      if (e_pen[k]) begin
        e_bank[k]  = e_pin;
        e_valid[k] = 1'b1;
      end
    end
    e_gnt = '0; e_pen = '0; e_busy = 1'b0; e_err = 1'b0;
    if (m_load) begin
      m_load = 1'b0;
    end else if (r != 4'b0) begin
      w = -1;
      for (int s = 0; s < NREQ; s++) begin
        c = (m_ptr + s) % NREQ;
        if (w < 0 && ((r >> c) & 4'b1) != 4'b0) w = c;
      end
      ta = int'((a >> (AW * w)) & 8'h3);
      e_gnt = 4'(1 << w);
      if (ta < NREG) e_pen = 4'(1 << ta);
      else           e_err = 1'b1;
      e_pin  = 10'((d >> (w * SIZE)) & 40'h3FF);
      e_busy = 1'b1;
      m_ptr  = (w + 1) % NREQ;
      m_load = 1'b1;
    end
  endtask

  initial begin
    vecs[0]  = '{4'hF, 8'hE4, RRD,     4'b0001, 4'b0001, 10'h0A0, 1'b1, 1'b0};
    vecs[1]  = '{4'hF, 8'hE4, RRD,     4'b0000, 4'b0000, 10'h0A0, 1'b0, 1'b0};
    vecs[2]  = '{4'hF, 8'hE4, RRD,     4'b0010, 4'b0010, 10'h0A1, 1'b1, 1'b0};
    vecs[3]  = '{4'hF, 8'hE4, RRD,     4'b0000, 4'b0000, 10'h0A1, 1'b0, 1'b0};
    vecs[4]  = '{4'hF, 8'hE4, RRD,     4'b0100, 4'b0100, 10'h0A2, 1'b1, 1'b0};
    vecs[5]  = '{4'hF, 8'hE4, RRD,     4'b0000, 4'b0000, 10'h0A2, 1'b0, 1'b0};
    vecs[6]  = '{4'hF, 8'hE4, RRD,     4'b1000, 4'b1000, 10'h0A3, 1'b1, 1'b0};
    vecs[7]  = '{4'hF, 8'hE4, RRD,     4'b0000, 4'b0000, 10'h0A3, 1'b0, 1'b0};
    vecs[8]  = '{4'hF, 8'hE4, RRD,     4'b0001, 4'b0001, 10'h0A0, 1'b1, 1'b0};
    vecs[9]  = '{4'h0, 8'hE4, RRD,     4'b0000, 4'b0000, 10'h0A0, 1'b0, 1'b0};
    vecs[10] = '{4'h1, 8'h02, 40'h155, 4'b0001, 4'b0100, 10'h155, 1'b1, 1'b0};
    vecs[11] = '{4'h0, 8'h02, 40'h155, 4'b0000, 4'b0000, 10'h155, 1'b0, 1'b0};

    rst = 1'b0; req = '0; addr = '0; wdata = '0;
    req3 = '0; addr3 = '0; wdata3 = '0;
    #3;
    chk("reset_outputs", outs(), pk(4'b0, 4'b0, 10'h0, 1'b0, 1'b0));
    tick; tick;
    rst = 1'b1;

    // Round-robin with all requesters held, then a single write to reg 2.
    for (int i = 0; i < 12; i++) begin
      req = vecs[i].req; addr = vecs[i].addr; wdata = vecs[i].wdata;
      tick;
      chk($sformatf("vec%0d", i), outs(),
          pk(vecs[i].gnt, vecs[i].pen, vecs[i].pin, vecs[i].busy, vecs[i].err));
    end
    chk("bank0_rr", 64'(bank[0]), 64'h0A0);
    chk("bank1_rr", 64'(bank[1]), 64'h0A1);
    chk("bank2_single", 64'(bank[2]), 64'h155);
    chk("bank3_rr", 64'(bank[3]), 64'h0A3);

    // Grant requester 2 to park the pointer at 3.
    req = 4'b0100; addr = 8'h10; wdata = 40'(10'h2AA) << 20;
    tick;
    chk("park_gnt", outs(), pk(4'b0100, 4'b0010, 10'h2AA, 1'b1, 1'b0));
    req = '0;
    tick;

    // Collision: requesters 1 and 2 both target reg 3 with ptr=3.
    req = 4'b0110; addr = 8'h3C; wdata = {10'h0, 10'h222, 10'h111, 10'h0};
    tick;
    chk("coll_first", outs(), pk(4'b0010, 4'b1000, 10'h111, 1'b1, 1'b0));
    req = 4'b0100;
    tick;
    chk("coll_load", outs(), pk(4'b0000, 4'b0000, 10'h111, 1'b0, 1'b0));
    tick;
    chk("coll_second", outs(), pk(4'b0100, 4'b1000, 10'h222, 1'b1, 1'b0));
    req = '0;
    tick;
    chk("coll_bank3", 64'(bank[3]), 64'h222);
    chk("park_bank1", 64'(bank[1]), 64'h2AA);

    // Reset asserted in the middle of a LOAD cycle aborts the write.
    req = 4'b0010; addr = 8'h04; wdata = 40'(10'h3C3) << 10;
    tick;
    chk("rst_pre_load", outs(), pk(4'b0010, 4'b0010, 10'h3C3, 1'b1, 1'b0));
    req = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outs", outs(), pk(4'b0, 4'b0, 10'h0, 1'b0, 1'b0));
    tick;
    chk("rst_bank1_kept", 64'(bank[1]), 64'h2AA);
    rst = 1'b1;

    // Withdrawn request: high and low again between two edges.
    req = 4'b0100; addr = 8'h00; wdata = 40'h1;
    #3 req = '0;
    tick;
    chk("withdraw_gnt", 64'(gnt), 64'h0);
    chk("withdraw_busy", 64'(busy), 64'h0);

    // Out-of-range target on the three-register instance.
    req3 = 4'b0001; addr3 = 8'h03; wdata3 = 40'h0F0;
    tick;
    chk("oor_outs", {44'b0, gnt3, 1'b0, pen3, pin3, busy3, err3},
        {44'b0, 4'b0001, 4'b0000, 10'h0F0, 1'b1, 1'b1});
    req3 = '0;
    tick;
    chk("oor_err_clear", {62'b0, busy3, err3}, 64'h0);
    chk("oor_bank_kept", {34'b0, bank3[0], bank3[1], bank3[2]}, 64'h0);

    // Randomized traffic against the model, starting from a fresh reset.
    rst = 1'b0;
    tick;
    rst = 1'b1;
    m_load = 1'b0; m_ptr = 0; e_gnt = '0; e_pen = '0; e_pin = '0; e_busy = 1'b0; e_err = 1'b0;
    for (int k = 0; k < 4; k++) begin e_bank[k] = '0; e_valid[k] = 1'b0; end
    for (int n = 0; n < 400; n++) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = '0;
      addr  = 8'($urandom);
      wdata = 40'({$urandom(), $urandom()});
      @(posedge clk);
      model_step(req, addr, wdata);
      #1;
      chk($sformatf("rand%0d", n), outs(), pk(e_gnt, e_pen, e_pin, e_busy, e_err));
    end
    req = '0;
    tick;
    model_step(4'b0, 8'h0, 40'h0);
    for (int k = 0; k < 4; k++) begin
      if (e_valid[k]) chk($sformatf("rand_bank%0d", k), 64'(bank[k]), 64'(e_bank[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
